// File: rtl/legv8_pkg.sv
// Shared LegV8 control-path types.
// PC-select encodings, fetch FSM states, instruction width.
package legv8_pkg;

  localparam int INSTR_WIDTH = 32;

  typedef enum logic [1:0] {
    PS_HOLD   = 2'b00,
    PS_INC    = 2'b01,
    PS_REG    = 2'b10,
    PS_BRANCH = 2'b11
  } ps_e;

  typedef enum logic {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } fetch_st_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read channel.
// req/addr held until ready samples high.
interface instr_fetch_unit_if
  import legv8_pkg::*;
#(
  parameter int PC_WIDTH = 64
);
  logic                   req;
  logic [PC_WIDTH-1:0]    addr;
  logic [INSTR_WIDTH-1:0] rdata;
  logic                   ready;

  modport master (
    output req,
    output addr,
    input  rdata,
    input  ready
  );

  modport slave (
    input  req,
    input  addr,
    output rdata,
    output ready
  );
endinterface

// File: rtl/pc_next_calc.sv
// Next-PC mux: hold, +4, register target, word branch.
// All adds wrap modulo 2^PC_WIDTH.
module pc_next_calc
  import legv8_pkg::*;
#(
  parameter int PC_WIDTH = 64
) (
  input  logic [1:0]          ps,
  input  logic [PC_WIDTH-1:0] k,
  input  logic [PC_WIDTH-1:0] reg_in,
  input  logic [PC_WIDTH-1:0] pc,
  output logic [PC_WIDTH-1:0] pc_next,
  output logic [PC_WIDTH-1:0] pc_next4
);

  localparam logic [PC_WIDTH-1:0] FOUR  = PC_WIDTH'(4);
  localparam logic [PC_WIDTH-1:0] ALIGN = ~PC_WIDTH'(3);

  always_comb begin
    pc_next = pc;
    unique case (ps_e'(ps))
      PS_HOLD:   pc_next = pc;
      PS_INC:    pc_next = pc + FOUR;
      PS_REG:    pc_next = reg_in & ALIGN;
      PS_BRANCH: pc_next = pc + (k << 2);
      default:   pc_next = pc;
    endcase
  end

  assign pc_next4 = pc_next + FOUR;

endmodule

// File: rtl/instr_fetch_unit.sv
// LegV8 fetch stage: PC, instruction register, FETCH/EXEC FSM.
// Multi-cycle instructions stay in EXEC while state_next is set.
module instr_fetch_unit
  import legv8_pkg::*;
#(
  parameter int                  PC_WIDTH = 64,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [1:0]             PS,
  input  logic [PC_WIDTH-1:0]    k,
  input  logic [PC_WIDTH-1:0]    reg_in,
  input  logic                   state_next,
  instr_fetch_unit_if.master     imem,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic                   instr_valid,
  output logic                   state,
  output logic [PC_WIDTH-1:0]    PC,
  output logic [PC_WIDTH-1:0]    PC4
);

  fetch_st_e              fsm_q, fsm_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [PC_WIDTH-1:0]    pc4_q, pc4_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic                   state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_next;
  logic [PC_WIDTH-1:0]    pc_next4;

  pc_next_calc #(
    .PC_WIDTH (PC_WIDTH)
  ) u_pc_next (
    .ps       (PS),
    .k        (k),
    .reg_in   (reg_in),
    .pc       (pc_q),
    .pc_next  (pc_next),
    .pc_next4 (pc_next4)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      fsm_q   <= FETCH;
      pc_q    <= RESET_PC;
      pc4_q   <= RESET_PC + PC_WIDTH'(4);
      instr_q <= '0;
      state_q <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
      instr_q <= instr_d;
      state_q <= state_d;
    end
  end

  always_comb begin
    fsm_d   = fsm_q;
    pc_d    = pc_q;
    pc4_d   = pc4_q;
    instr_d = instr_q;
    state_d = state_q;
    unique case (fsm_q)
      FETCH: begin
        if (imem.ready) begin
          instr_d = imem.rdata;
          state_d = 1'b0;
          fsm_d   = EXEC;
        end
      end
      EXEC: begin
        pc_d  = pc_next;
        pc4_d = pc_next4;
        if (state_next) begin
          state_d = 1'b1;
        end else begin
          state_d = 1'b0;
          fsm_d   = FETCH;
        end
      end
      default: fsm_d = FETCH;
    endcase
  end

  // Reset gating keeps req/valid low before the first reset edge.
  assign imem.req    = (fsm_q == FETCH) & ~reset;
  assign imem.addr   = pc_q;
  assign instr_valid = (fsm_q == EXEC) & ~reset;
  assign instr       = instr_q;
  assign state       = state_q;
  assign PC          = pc_q;
  assign PC4         = pc4_q;

endmodule
